// File: rtl/dec_bcd_encoder_if.sv
// rtl/dec_bcd_encoder_if.sv - decimal panel lines in, BCD/strobe/status out
interface dec_bcd_encoder_if;
  logic _0, _1, _2, _3, _4, _5, _6, _7, _8, _9;
  logic _A, _B, _C, _D;
  logic strobe;
  logic held;
  logic multi;

  modport master (
    output _0, _1, _2, _3, _4, _5, _6, _7, _8, _9,
    input  _A, _B, _C, _D, strobe, held, multi
  );

  modport slave (
    input  _0, _1, _2, _3, _4, _5, _6, _7, _8, _9,
    output _A, _B, _C, _D, strobe, held, multi
  );
endinterface

// File: rtl/dec_bcd_encoder.sv
// rtl/dec_bcd_encoder.sv - debounced active-low decimal to BCD encoder
// Optional DEC_BCD_ENCODER_PRIORITY_EN: multi-press resolves to highest index.
module dec_bcd_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic          clk,
  input logic          reset,
  dec_bcd_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, QUAL, HOLD, REL} state_t;

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [9:0] sync1, sync2;
  logic [9:0] act;
  logic       is_none, is_multi, valid;
  logic [3:0] code;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] cand, cand_n;
  logic       accept;
  logic [3:0] bcd;
  logic       strobe_r, multi_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {bus._9, bus._8, bus._7, bus._6, bus._5,
                bus._4, bus._3, bus._2, bus._1, bus._0};
      sync2 <= sync1;
    end
  end

  // Highest active index wins; for a single line that is simply its index.
  always_comb begin
    act      = ~sync2;
    is_none  = (act == 10'd0);
    is_multi = !is_none && ($countones(act) != 1);
    code     = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (act[i]) code = 4'(i);
    end
`ifdef DEC_BCD_ENCODER_PRIORITY_EN
    valid = !is_none;
`else
    valid = !is_none && !is_multi;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      cand     <= 4'd0;
      bcd      <= 4'd0;
      strobe_r <= 1'b0;
      multi_r  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cand     <= cand_n;
      strobe_r <= accept;
      multi_r  <= is_multi;
      if (accept) bcd <= cand;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          state_n = QUAL;
          cand_n  = code;
          cnt_n   = 8'd1;
        end
      end
      QUAL: begin
        if (valid && code == cand) begin
          if (cnt >= LAST) begin
            state_n = HOLD;
            accept  = 1'b1;
            cnt_n   = 8'd0;
          end else if (cnt != 8'hFF) begin
            cnt_n = cnt + 8'd1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (is_none) begin
          state_n = REL;
          cnt_n   = 8'd1;
        end
      end
      REL: begin
        if (is_none) begin
          if (cnt >= LAST) begin
            state_n = IDLE;
            cnt_n   = 8'd0;
          end else if (cnt != 8'hFF) begin
            cnt_n = cnt + 8'd1;
          end
        end else begin
          state_n = HOLD;
          cnt_n   = 8'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus._A     = bcd[0];
    bus._B     = bcd[1];
    bus._C     = bcd[2];
    bus._D     = bcd[3];
    bus.strobe = strobe_r;
    bus.multi  = multi_r;
    bus.held   = (state == HOLD) || (state == REL);
  end
endmodule

// File: tb/tb_dec_bcd_encoder.sv
// tb/tb_dec_bcd_encoder.sv - scoreboard bench for dec_bcd_encoder
module tb_dec_bcd_encoder;
  logic clk;
  logic reset;

  dec_bcd_encoder_if bus ();

  dec_bcd_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0] code;
    logic       mul;
    logic [9:0] lines;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] ls42(input logic [3:0] c);
    logic [9:0] r;
    r = 10'h3FF;
    if (c <= 4'd9) r[c] = 1'b0;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] v);
    {bus._9, bus._8, bus._7, bus._6, bus._5, bus._4, bus._3, bus._2, bus._1, bus._0} = v;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] c, input logic m, input logic [9:0] l);
    exp_t e;
    e.code = c;
    e.mul = m;
    e.lines = l;
    q.push_back(e);
  endtask

  function automatic logic [3:0] bcd_out();
    return {bus._D, bus._C, bus._B, bus._A};
  endfunction

  // Monitor: every strobe consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!reset && bus.strobe === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: got code %0d expected no strobe", bcd_out());
      end else begin
        exp_t e;
        e = q.pop_front();
        check("strobe_code", 32'(bcd_out()), 32'(e.code));
        check("strobe_multi", 32'(bus.multi), 32'(e.mul));
        check("ls42_loopback", 32'(ls42(bcd_out())), 32'(e.lines));
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive(~(10'b1 << 5));

    // Reset with _5 pressed, then release and watch the 6-edge latency.
    step(3);
    check("reset_code", 32'(bcd_out()), 32'd0);
    check("reset_strobe", 32'(bus.strobe), 32'd0);
    check("reset_held", 32'(bus.held), 32'd0);
    check("reset_multi", 32'(bus.multi), 32'd0);
    push(4'd5, 1'b0, ~(10'b1 << 5));
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("latency_no_strobe_edge5", 32'(bus.strobe), 32'd0);
    @(negedge clk);
    check("latency_strobe_edge6", 32'(bus.strobe), 32'd1);
    step(3);
    drive(10'h3FF);
    step(10);

    // Sweep 0..9.
    for (int n = 0; n < 10; n++) begin
      push(4'(n), 1'b0, ~(10'b1 << n));
      drive(~(10'b1 << n));
      step(10);
      check("sweep_held", 32'(bus.held), 32'd1);
      drive(10'h3FF);
      step(10);
      check("sweep_released", 32'(bus.held), 32'd0);
    end

    // Bounce on _9: 2 low / 2 high never reaches 4 consecutive samples.
    for (int i = 0; i < 5; i++) begin
      drive(~(10'b1 << 9));
      step(2);
      drive(10'h3FF);
      step(2);
    end
    step(4);
    check("bounce_code", 32'(bcd_out()), 32'd9);
    check("bounce_held", 32'(bus.held), 32'd0);
    push(4'd9, 1'b0, ~(10'b1 << 9));
    drive(~(10'b1 << 9));
    step(10);
    drive(10'h3FF);
    step(10);

    // Release bounce on _3.
    push(4'd3, 1'b0, ~(10'b1 << 3));
    drive(~(10'b1 << 3));
    step(10);
    drive(10'h3FF);
    step(2);
    drive(~(10'b1 << 3));
    step(6);
    check("relbounce_held", 32'(bus.held), 32'd1);
    drive(10'h3FF);
    step(4);
    check("release_held_edge3", 32'(bus.held), 32'd1);
    step(2);
    check("release_dropped_edge5", 32'(bus.held), 32'd0);
    step(4);

    // Multi-press _2 + _8.
`ifdef DEC_BCD_ENCODER_PRIORITY_EN
    push(4'd8, 1'b1, ~(10'b1 << 8));
`endif
    drive(~((10'b1 << 2) | (10'b1 << 8)));
    step(10);
    check("multi_flag", 32'(bus.multi), 32'd1);
`ifdef DEC_BCD_ENCODER_PRIORITY_EN
    check("multi_held", 32'(bus.held), 32'd1);
    check("multi_code", 32'(bcd_out()), 32'd8);
`else
    check("multi_held", 32'(bus.held), 32'd0);
    check("multi_code", 32'(bcd_out()), 32'd3);
`endif
    drive(10'h3FF);
    step(10);
    check("multi_cleared", 32'(bus.multi), 32'd0);

    // Reset during QUAL on _6.
    drive(~(10'b1 << 6));
    step(3);
    reset = 1'b1;
    step(2);
    check("qreset_code", 32'(bcd_out()), 32'd0);
    check("qreset_held", 32'(bus.held), 32'd0);
    check("qreset_strobe", 32'(bus.strobe), 32'd0);
    drive(10'h3FF);
    reset = 1'b0;
    step(10);
    check("qreset_code_after", 32'(bcd_out()), 32'd0);
    check("qreset_idle", 32'(bus.held), 32'd0);

    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dec_bcd_encoder.md
# dec_bcd_encoder

Registered 10-line active-low decimal to 4-bit BCD encoder with input synchronisation and press/release debounce. It is the encoding counterpart of the LS42 BCD-to-decimal decoder. It sits between panel or switch inputs (DIP banks, coin/test selectors) and logic that consumes BCD. Its `_A`..`_D` outputs connect directly to the decoder's inputs for loopback checking.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive identical samples required to accept a press and to accept a release. Legal range 2..255.

Ports:
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `_0`..`_9` input 1 each: decimal lines, active-low, asynchronous to `clk`.
- `_A`, `_B`, `_C`, `_D` output 1 each: true (active-high) BCD of the accepted digit. `_A` is the LSB.
- `strobe` output 1: one-cycle pulse when a new digit is accepted.
- `held` output 1: high while an accepted digit is pressed or its release is being debounced.
- `multi` output 1: high while the synchronised sample has more than one line active.

## Operation
- **Synchroniser:** each `_n` passes through a 2-flop synchroniser; all logic below uses the second stage.
- **Sample classification:** each synchronised sample is one of NONE (all high), SINGLE(n), or MULTI.
- **Effective code:** SINGLE(n) gives n. MULTI behaviour is set in Configuration.
- **FSM state IDLE:**
  - Valid code → QUAL; `cand` := code; `cnt` := 1.
  - NONE or invalid → stay in IDLE.
- **FSM state QUAL:**
  - Code == `cand` → `cnt`++.
  - When the incoming sample is the `DEBOUNCE_CYCLES`-th consecutive match → HOLD. On that edge, `{_D,_C,_B,_A}` := `cand` and `strobe` := 1.
  - Code differs from `cand` (including NONE or invalid) → IDLE. The outputs are not touched.
- **FSM state HOLD:**
  - NONE → REL with `cnt` := 1.
  - Any other sample → stay in HOLD. A digit change while held is ignored.
- **FSM state REL:**
  - NONE → `cnt`++. When the `DEBOUNCE_CYCLES`-th consecutive NONE arrives → IDLE.
  - Any non-NONE sample → HOLD; `cnt` cleared.
- **Outputs:**
  - `_A`..`_D` keep the last accepted digit indefinitely. They change only on a HOLD entry from QUAL.
  - `held` = (state == HOLD or state == REL).
  - `strobe` is high only in the cycle after the accepting edge.
  - `multi` is registered from the synchronised sample.
- **Counter:** 8 bits. It saturates and never wraps, because the state change occurs before overflow.
- **Reset values:**
  - State IDLE; `cnt` = 0; `cand` = 0.
  - `_A`..`_D` = 0000; `strobe`, `held`, `multi` = 0.
  - Both synchroniser stages = 1 (lines inactive).
- **Reset mid-operation:** any state returns to IDLE immediately. A digit that is still pressed after reset is re-qualified and re-strobed.

## Timing
- Pin low before edge k: synchronised value is visible after edge k+1, and the first sample is taken at edge k+2.
- Press latency: `strobe` is high and the outputs are valid in the cycle after edge k+1+`DEBOUNCE_CYCLES` (default 4: after edge k+5).
- Release: `held` drops after edge k'+1+`DEBOUNCE_CYCLES`, where the pin returns high before edge k'.
- The earliest next strobe comes `DEBOUNCE_CYCLES` samples after re-entering IDLE.
- `multi` lags the pin by 3 edges.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles never produce `strobe` and never alter `_A`..`_D`.

## Configuration
Macro `DEC_BCD_ENCODER_PRIORITY_EN`:
- **Defined:** LS147-style priority. MULTI resolves to the highest active index (e.g. `_3` and `_7` low → 7). `multi` still reports the condition.
- **Undefined:** MULTI is invalid.
  - In IDLE it is ignored.
  - In QUAL it aborts to IDLE.
  - In HOLD it holds.
  - In REL it returns to HOLD.

## Test plan
- **Reset:** assert `reset` with `_5` low → `_A`..`_D` = 0000, `strobe` = 0, `held` = 0. Release reset and keep `_5` low → one `strobe` after 6 edges, with `{_D,_C,_B,_A}` = 0101.
- **Sweep 0–9:** press each digit 0..9 for 10 cycles, then release for 10 cycles → one `strobe` per digit with code = n. Looping `_A`..`_D` through the LS42 model drives only line n low.
- **Bounce:** toggle `_9` low/high every 2 cycles for 20 cycles (`DEBOUNCE_CYCLES` = 4) → no `strobe`, outputs unchanged. Then hold it low → a single `strobe` with code 1001.
- **Release bounce:** while 3 is held, pulse the input high for 2 cycles, then low again → `held` stays 1 and no second `strobe`. Release for 4+ cycles → `held` = 0.
- **Multi-press:** press `_2` and `_8` together.
  - Macro defined: `strobe` with code 1000 and `multi` = 1.
  - Macro undefined: no `strobe` and `multi` = 1.
- **Reset during QUAL:** press `_6` and assert `reset` at the second sample → no `strobe`, outputs 0000, state returns to IDLE.
